serial_code_recognizer_p: RTL and testbench
===========================================

Name: serial_code_recognizer_p

Overview:
- Parametrised successor of the serial BCD recognizer FSM.
- Deserialises a gated serial bit stream on `linea` into MSB-first groups of GROUP_W bits.
- Classifies each completed group as accepted (value <= MAX_CODE) or rejected, and keeps saturating accept/reject tallies.
- Sits between the serial line front-end and the status/interrupt logic of the benchmark-style datapath.

Parameters:
- GROUP_W, 4, bits per group; legal range 2..16.
- MAX_CODE, 9, largest accepted group value; must be < 2**GROUP_W.
- CNT_W, 8, width of the accept and reject counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of the group in progress and both counters.
- linea_valid  in  1  qualifies `linea`; a bit is consumed only when high.
- linea  in  1  serial data bit, MSB of each group first.
- u  out  1  one-cycle pulse: last group accepted.
- err  out  1  one-cycle pulse: last group rejected.
- group_done  out  1  one-cycle pulse: a group completed; equals u | err.
- group_out  out  GROUP_W  value of the last completed group; held until the next completion.
- accept_cnt  out  CNT_W  saturating count of accepted groups.
- reject_cnt  out  CNT_W  saturating count of rejected groups.
- busy  out  1  high while a partial group is held (state COLLECT).

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE; bit counter and shift register are 0.
  - u, err, group_done and busy are 0; group_out is 0; both counters are 0.
- State machine, two states:
  - IDLE: no partial group. A valid bit loads into shift[0], sets bit counter to 1 and moves to COLLECT. With GROUP_W=1 this would complete immediately, which is why GROUP_W >= 2.
  - COLLECT: each valid bit gives shift <= {shift[GROUP_W-2:0], linea} and increments the bit counter.
  - When the valid bit is bit GROUP_W (counter == GROUP_W-1 before the edge), the group completes: return to IDLE and clear the counter.
- Completion timing:
  - On the edge that consumes the last bit, the full group value V = {shift, linea} is registered.
  - group_out <= V and group_done <= 1.
  - u <= (V <= MAX_CODE) and err <= (V > MAX_CODE).
  - Pulses are visible in the cycle after the last bit: latency 1 clock. They drop the following cycle unless another group completes.
- Counters:
  - accept_cnt increments on an accepted group; reject_cnt increments on a rejected group.
  - Both saturate at 2**CNT_W-1 with no wrap.
  - Only one counter can change per cycle.
- Valid gaps: linea_valid low holds all state. Pulses still clear after one cycle. Gaps inside a group do not abort it.
- clear high:
  - Next state is IDLE with counter, shift and both counters at 0; u, err and group_done are 0.
  - group_out is held.
  - clear takes priority over a simultaneous valid bit, which is discarded, including a would-be final bit.
- Reset mid-group: the partial group is lost with no pulse; the next valid bit after release is treated as an MSB.
- busy = (state == COLLECT), registered.
- Back-to-back groups: the last bit of group N and the first bit of group N+1 on consecutive cycles must both be consumed with no bubble.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- When defined:
  - Each group is followed by one even-parity bit, so the frame is GROUP_W+1 valid bits.
  - Completion occurs on the parity bit.
  - Accept requires V <= MAX_CODE and XOR(V, parity) == 0.
  - An extra output port `parity_err` (1 bit) pulses alongside err when parity fails. A parity failure counts as a reject.
  - group_out still carries V only.
- When undefined: GROUP_W-bit frames, no parity_err port, behaviour as above.

Test Plan:
- Reset then serial 0,1,1,1 (value 7), all valid on consecutive cycles -> one cycle after the 4th bit: u=1, err=0, group_done=1, group_out=4'h7, accept_cnt=1; all pulses 0 the next cycle.
- Serial 1,0,1,0 (value 10) -> err=1, u=0, group_out=4'hA, reject_cnt=1, accept_cnt unchanged.
- Bits of value 9 split by 3 idle cycles of linea_valid=0 -> busy=1 during the gap, u=1 after the 4th valid bit, group_out=4'h9.
- clear asserted on the cycle carrying the 4th bit of value 3 -> no pulse, counters 0, busy=0; next 4 bits 1,0,0,0 -> group_out=4'h8, accept_cnt=1.
- CNT_W=2, feed 5 accepted groups back-to-back -> accept_cnt reads 1,2,3,3,3; u pulses 5 times with no bubble between groups.
- reset_n pulsed low after 2 bits of a group, then 4 bits of 0xF -> no pulse for the partial group; err=1 and group_out=4'hF after the full group. With SERIAL_PARITY_EN, value 5 followed by parity 1 -> err=1, parity_err=1.

Source files
------------

// File: rtl/serial_code_recognizer_p.sv
// serial_code_recognizer_p: deserialises a gated, MSB-first serial stream into
// GROUP_W-bit groups and classifies each group as accepted (value <= MAX_CODE)
// or rejected. Accept and reject tallies saturate at 2**CNT_W-1.
// Optional feature macro: SERIAL_PARITY_EN. When it is defined, each group is
// followed by an even-parity bit, a parity failure counts as a reject, and the
// parity_err pulse output is present.
module serial_code_recognizer_p #(
  parameter int GROUP_W  = 4,
  parameter int MAX_CODE = 9,
  parameter int CNT_W    = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               linea_valid,
  input  logic               linea,
  output logic               u,
  output logic               err,
  output logic               group_done,
  output logic [GROUP_W-1:0] group_out,
  output logic [CNT_W-1:0]   accept_cnt,
  output logic [CNT_W-1:0]   reject_cnt,
`ifdef SERIAL_PARITY_EN
  output logic               parity_err,
`endif
  output logic               busy
);

`ifdef SERIAL_PARITY_EN
  // Frame = data bits + parity bit; the shifter keeps the whole data value.
  localparam int FRAME_W = GROUP_W + 1;
  localparam int SHIFT_W = GROUP_W;
`else
  // Frame = data bits; the final bit is taken straight from the line.
  localparam int FRAME_W = GROUP_W;
  localparam int SHIFT_W = GROUP_W - 1;
`endif
  localparam int BCNT_W = $clog2(FRAME_W);
  localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

`ifdef SERIAL_PARITY_EN
  // Even parity holds when the XOR of data and parity bit is zero.
  function automatic logic parity_ok(input logic [GROUP_W:0] frame);
    return (^frame) == 1'b0;
  endfunction
`endif

  state_t             state_q;
  logic [BCNT_W-1:0]  bit_cnt_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               u_q;
  logic               err_q;
  logic               done_q;
  logic [GROUP_W-1:0] group_q;
  logic [CNT_W-1:0]   acc_q;
  logic [CNT_W-1:0]   rej_q;
`ifdef SERIAL_PARITY_EN
  logic               perr_q;
`endif

  logic [SHIFT_W-1:0] shift_d;
  logic               last_d;
  logic [GROUP_W-1:0] value_d;
  logic               par_ok_d;
  logic               accept_d;

  // Next shift value, final-bit detection and classification of the frame.
  always_comb begin
    shift_d = SHIFT_W'({shift_q, linea});
    last_d  = (state_q == COLLECT) && (bit_cnt_q == LAST_CNT);
`ifdef SERIAL_PARITY_EN
    value_d  = shift_q;
    par_ok_d = parity_ok({shift_q, linea});
`else
    value_d  = {shift_q, linea};
    par_ok_d = 1'b1;
`endif
    if ((value_d <= GROUP_W'(MAX_CODE)) && par_ok_d) begin
      accept_d = 1'b1;
    end else begin
      accept_d = 1'b0;
    end
  end

  // Recognizer FSM with registered pulses, group value and saturating tallies.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      u_q       <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      group_q   <= '0;
      acc_q     <= '0;
      rej_q     <= '0;
`ifdef SERIAL_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else if (clear) begin
      // Clear wins over a coincident bit; the last completed value is kept.
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      u_q       <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      rej_q     <= '0;
`ifdef SERIAL_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      u_q    <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (linea_valid) begin
        case (state_q)
          IDLE: begin
            shift_q   <= SHIFT_W'(linea);
            bit_cnt_q <= BCNT_W'(1);
            state_q   <= COLLECT;
          end
          COLLECT: begin
            if (last_d) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              shift_q   <= '0;
              group_q   <= value_d;
              done_q    <= 1'b1;
              u_q       <= accept_d;
              err_q     <= ~accept_d;
`ifdef SERIAL_PARITY_EN
              perr_q    <= ~par_ok_d;
`endif
              if (accept_d && (acc_q != CNT_MAX)) begin
                acc_q <= acc_q + CNT_W'(1);
              end else if (!accept_d && (rej_q != CNT_MAX)) begin
                rej_q <= rej_q + CNT_W'(1);
              end
            end else begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
            end
          end
          default: begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        endcase
      end
    end
  end

  assign u          = u_q;
  assign err        = err_q;
  assign group_done = done_q;
  assign group_out  = group_q;
  assign accept_cnt = acc_q;
  assign reject_cnt = rej_q;
  assign busy       = (state_q == COLLECT);
`ifdef SERIAL_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_code_recognizer_p.sv
// Scoreboard bench for serial_code_recognizer_p: a bit-queue reference model
// predicts each completed group and per-cycle status; a monitor compares.
module tb_serial_code_recognizer_p;
  localparam int GW   = 4;
  localparam int MAXC = 9;
  localparam int CW   = 8;
  localparam int CW2  = 2;
`ifdef SERIAL_PARITY_EN
  localparam int FW = GW + 1;
`else
  localparam int FW = GW;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  logic linea_valid = 1'b0;
  logic linea = 1'b0;

  logic          u, err, group_done, busy;
  logic [GW-1:0] group_out;
  logic [CW-1:0] accept_cnt, reject_cnt;
  logic           s_u, s_err, s_done, s_busy;
  logic [GW-1:0]  s_gout;
  logic [CW2-1:0] s_acc, s_rej;
`ifdef SERIAL_PARITY_EN
  logic parity_err, s_perr;
`endif

  serial_code_recognizer_p #(.GROUP_W(GW), .MAX_CODE(MAXC), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .linea_valid(linea_valid), .linea(linea),
    .u(u), .err(err), .group_done(group_done), .group_out(group_out),
    .accept_cnt(accept_cnt), .reject_cnt(reject_cnt),
`ifdef SERIAL_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy));

  serial_code_recognizer_p #(.GROUP_W(GW), .MAX_CODE(MAXC), .CNT_W(CW2)) dut_sat (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .linea_valid(linea_valid), .linea(linea),
    .u(s_u), .err(s_err), .group_done(s_done), .group_out(s_gout),
    .accept_cnt(s_acc), .reject_cnt(s_rej),
`ifdef SERIAL_PARITY_EN
    .parity_err(s_perr),
`endif
    .busy(s_busy));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int due; int val; bit u; bit e; bit pe; } grp_t;
  typedef struct { int due; bit busy; int gout; int acc; int rej; int acc2; int rej2; } st_t;
  grp_t grp_q[$];
  st_t  st_q[$];

  // Reference model state
  int bits[$];
  int m_acc = 0, m_rej = 0, m_acc2 = 0, m_rej2 = 0, m_gout = 0;
  int sat1 = (1 << CW) - 1;
  int sat2 = (1 << CW2) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_status();
    st_t s;
    s.due = cyc + 1; s.busy = (bits.size() > 0); s.gout = m_gout;
    s.acc = m_acc; s.rej = m_rej; s.acc2 = m_acc2; s.rej2 = m_rej2;
    st_q.push_back(s);
  endtask

  task automatic model_clear_counts();
    bits.delete();
    m_acc = 0; m_rej = 0; m_acc2 = 0; m_rej2 = 0;
  endtask

  task automatic model_complete();
    grp_t g;
    int val = 0;
    int ones = 0;
    bit pok;
    for (int i = 0; i < GW; i++) val = val * 2 + bits[i];
    for (int i = 0; i < FW; i++) ones += bits[i];
    pok = (FW == GW) ? 1'b1 : ((ones % 2) == 0);
    g.due = cyc + 1; g.val = val; g.u = (val <= MAXC) && pok; g.e = !g.u; g.pe = !pok;
    m_gout = val;
    if (g.u) begin
      m_acc = (m_acc < sat1) ? m_acc + 1 : sat1;
      m_acc2 = (m_acc2 < sat2) ? m_acc2 + 1 : sat2;
    end else begin
      m_rej = (m_rej < sat1) ? m_rej + 1 : sat1;
      m_rej2 = (m_rej2 < sat2) ? m_rej2 + 1 : sat2;
    end
    grp_q.push_back(g);
    bits.delete();
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    @(negedge clock); #1;
    linea_valid = v; linea = b; clear = c;
    if (c) model_clear_counts();
    else if (v) begin
      bits.push_back(int'(b));
      if (bits.size() == FW) model_complete();
    end
    push_status();
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset_n = 1'b0; linea_valid = 1'b0; clear = 1'b0;
    model_clear_counts();
    m_gout = 0;
    push_status();
    @(negedge clock); #1;
    reset_n = 1'b1;
    push_status();
  endtask

  task automatic send_group(input int v);
    for (int i = GW - 1; i >= 0; i--) step(1'b1, 1'(v >> i), 1'b0);
`ifdef SERIAL_PARITY_EN
    step(1'b1, ^(4'(v)), 1'b0);
`endif
  endtask

  // Monitor: per-cycle status plus pop-and-compare on every DUT completion.
  always @(negedge clock) begin : mon
    st_t s;
    grp_t g;
    if (st_q.size() > 0 && st_q[0].due == cyc) begin
      s = st_q.pop_front();
      check("busy", busy, s.busy);
      check("busy_sat", s_busy, s.busy);
      check("group_out_held", group_out, s.gout);
      check("accept_cnt", accept_cnt, s.acc);
      check("reject_cnt", reject_cnt, s.rej);
      check("accept_cnt_sat", s_acc, s.acc2);
      check("reject_cnt_sat", s_rej, s.rej2);
    end
    if (group_done === 1'b1) begin
      if (grp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got group_done=1 with group_out=%0d expected no completion (cycle %0d)", group_out, cyc);
      end else begin
        g = grp_q.pop_front();
        check("latency", cyc, g.due);
        check("group_value", group_out, g.val);
        check("u", u, g.u);
        check("err", err, g.e);
        check("sat_done", s_done, 1);
        check("sat_u", s_u, g.u);
        check("sat_err", s_err, g.e);
        check("sat_group_value", s_gout, g.val);
`ifdef SERIAL_PARITY_EN
        check("parity_err", parity_err, g.pe);
        check("sat_parity_err", s_perr, g.pe);
`endif
      end
    end else begin
      check("idle_u", u, 0);
      check("idle_err", err, 0);
      check("sat_idle_done", s_done, 0);
      if (grp_q.size() > 0 && grp_q[0].due <= cyc) begin
        g = grp_q.pop_front();
        total++; bad++;
        $display("FAIL missed_group: got no group_done expected value %0d (cycle %0d)", g.val, cyc);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    do_reset();
    send_group(7);
    step(1'b0, 1'b0, 1'b0);
    send_group(10);
    step(1'b0, 1'b0, 1'b0);
    // value 9 with a three-cycle valid gap inside the group
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
`ifdef SERIAL_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0);
    // clear on the final bit of value 3
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
`ifdef SERIAL_PARITY_EN
    step(1'b1, 1'b1, 1'b0);
`endif
    step(1'b1, 1'b1, 1'b1);
    send_group(8);
    // five accepted groups back-to-back
    repeat (5) send_group(2);
    // reset in the middle of a group
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_reset();
    send_group(15);
`ifdef SERIAL_PARITY_EN
    // value 5 with wrong parity bit
    for (int i = GW - 1; i >= 0; i--) step(1'b1, 1'(5 >> i), 1'b0);
    step(1'b1, 1'b1, 1'b0);
`endif
    step(1'b0, 1'b0, 1'b0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else step(r < 150, 1'($urandom), r >= 196);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);
    @(negedge clock); #1;
    check("leftover_groups", grp_q.size(), 0);
    check("leftover_status", st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
